// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH_DEF = 8;

    function automatic int mul_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_adder_row.sv
// WIDTH-bit ripple-carry adder row with carry in and carry out.
module mul_adder_row
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add multiplier, one partial product per clock, valid/ready on both sides.
// Define SIGNED_MUL_EN to add two's-complement operation selected by is_signed.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one add/shift step per clock, WIDTH steps
//   DONE  | product presented, held until out_ready
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mul
);

    localparam int CNT_W = mul_cnt_w(WIDTH);

    mul_state_t             r_state;
    mul_state_t             w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_mcand;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mul;

    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic [WIDTH-1:0]       w_op_a;
    logic [WIDTH-1:0]       w_op_b;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;
    logic [2*WIDTH-1:0]     w_acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_load = (r_state == IDLE) && in_valid;
    assign w_step = (r_state == RUN);
    assign w_last = w_step && (r_cnt == CNT_W'(WIDTH - 1));

    assign w_addend = r_acc[0] ? r_mcand : '0;

    mul_adder_row #(
        .WIDTH (WIDTH)
    ) u_adder_row (
        .i_a    (r_acc[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Carry-out lands in the top bit of the high half after the right shift.
    assign w_acc_next = {w_cout, w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mul   <= '0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_mcand <= w_op_a;
            r_acc   <= {{WIDTH{1'b0}}, w_op_b};
        end else if (w_step) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_acc   <= w_acc_next;
            if (w_last) begin
                r_mul <= w_acc_next;
            end
        end
    end

`ifdef SIGNED_MUL_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_sign;
    logic r_mul_neg;

    assign w_neg_a = is_signed & a[WIDTH-1];
    assign w_neg_b = is_signed & b[WIDTH-1];
    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign w_op_a  = w_neg_a ? -a : a;
    assign w_op_b  = w_neg_b ? -b : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_mul_neg <= 1'b0;
        end else if (w_load) begin
            r_sign    <= w_neg_a ^ w_neg_b;
        end else if (w_last) begin
            r_mul_neg <= r_sign;
        end
    end

    assign mul = r_mul_neg ? -r_mul : r_mul;
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_op_a = a;
    assign w_op_b = b;
    assign mul    = r_mul;
`endif

endmodule
